// File: rtl/regfile_sb.sv
// regfile_sb: 2R/1W register file with RAW scoreboard and bulk-clear engine.
// Define REGFILE_SB_BYPASS_EN for write-through forwarding to the read ports.
module regfile_sb #(
    parameter int DATA_W  = 32,
    parameter int ADDR_W  = 5,
    parameter int R0_ZERO = 1
) (
    input  logic              CLK,
    input  logic              RSTn,
    input  logic [ADDR_W-1:0] rs,
    input  logic [ADDR_W-1:0] rt,
    output logic [DATA_W-1:0] Data1,
    output logic [DATA_W-1:0] Data2,
    output logic              Busy1,
    output logic              Busy2,
    input  logic              RegWre,
    input  logic [ADDR_W-1:0] writeReg,
    input  logic              DBDataSrc,
    input  logic [DATA_W-1:0] dataFromALU,
    input  logic [DATA_W-1:0] dataFromRW,
    input  logic              IssueValid,
    input  logic [ADDR_W-1:0] IssueReg,
    input  logic              ClearReq,
    output logic              ClearBusy,
    output logic              ClearDone
);

    localparam int DEPTH = 1 << ADDR_W;
    localparam bit RZ    = (R0_ZERO != 0);

    typedef enum logic [1:0] {
        IDLE,
        CLEAR,
        DONE
    } state_t;

    state_t state, state_nx;

    logic [ADDR_W-1:0] cnt, cnt_nx;
    logic [DATA_W-1:0] regs [DEPTH];
    logic [DEPTH-1:0]  busy;

    logic              idle;
    logic              wr_en;
    logic              iss_en;
    logic [DATA_W-1:0] wdata;

    assign idle   = (state == IDLE);
    assign wdata  = DBDataSrc ? dataFromRW : dataFromALU;
    assign wr_en  = RegWre && idle && !(RZ && writeReg == '0);
    assign iss_en = IssueValid && idle && !(RZ && IssueReg == '0);

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
        end
    end

    always_comb begin
        state_nx  = state;
        cnt_nx    = cnt;
        ClearBusy = 1'b0;
        ClearDone = 1'b0;
        unique case (state)
            IDLE: begin
                if (ClearReq) begin
                    state_nx = CLEAR;
                    cnt_nx   = RZ ? ADDR_W'(1) : '0;
                end
            end
            CLEAR: begin
                ClearBusy = 1'b1;
                // counter parks at the last index rather than wrapping
                if (&cnt) state_nx = DONE;
                else      cnt_nx   = cnt + 1'b1;
            end
            DONE: begin
                ClearDone = 1'b1;
                state_nx  = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            for (int i = 0; i < DEPTH; i++) regs[i] <= '0;
        end else begin
            if (wr_en)            regs[writeReg] <= wdata;
            if (state == CLEAR)   regs[cnt]      <= '0;
        end
    end

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            busy <= '0;
        end else if (idle && ClearReq) begin
            busy <= '0;
        end else begin
            // set after clear so a new producer supersedes the retiring one
            if (wr_en)  busy[writeReg] <= 1'b0;
            if (iss_en) busy[IssueReg] <= 1'b1;
        end
    end

    logic [DATA_W-1:0] rd1, rd2;
    logic              bz1, bz2;

    always_comb begin
        rd1 = regs[rs];
        rd2 = regs[rt];
        bz1 = busy[rs];
        bz2 = busy[rt];
        if (RZ && rs == '0) begin
            rd1 = '0;
            bz1 = 1'b0;
        end
        if (RZ && rt == '0) begin
            rd2 = '0;
            bz2 = 1'b0;
        end
`ifdef REGFILE_SB_BYPASS_EN
        if (wr_en && writeReg == rs) begin
            rd1 = wdata;
            bz1 = 1'b0;
        end
        if (wr_en && writeReg == rt) begin
            rd2 = wdata;
            bz2 = 1'b0;
        end
`endif
    end

    assign Data1 = rd1;
    assign Data2 = rd2;
    assign Busy1 = bz1;
    assign Busy2 = bz2;

endmodule
